// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster timing generator with registered sync/colour outputs and line-buffer prefetch hints.
// Define VGA_TESTPAT_EN to build the 8-bar colour test pattern selected by testpat.
module vga_scan_gen #(
   parameter int   H_ACTIVE = 512,
   parameter int   H_FP     = 58,
   parameter int   H_SYNC   = 82,
   parameter int   H_BP     = 30,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 32,
   parameter int   CW       = 4,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            sync,
   input  logic            border,
   input  logic            testpat,
   input  logic [3*CW-1:0] pixel,
   output logic            vga_h,
   output logic            vga_v,
   output logic [CW-1:0]   vga_r,
   output logic [CW-1:0]   vga_g,
   output logic [CW-1:0]   vga_b,
   output logic            vga_de,
   output logic [10:0]     hcount,
   output logic [10:0]     vcount,
   output logic [10:0]     next_x,
   output logic            next_buf,
   output logic            frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] H_EDGE = 11'(H_ACTIVE - 1);
   localparam logic [10:0] V_EDGE = 11'(V_ACTIVE - 1);
   localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0]     h, v;
   logic            hwrap, fwrap, active, edge_px, fs_pend;
   logic [3*CW-1:0] src;

   assign hwrap    = h == H_LAST;
   assign fwrap    = hwrap && v == V_LAST;
   assign active   = h < H_ACT && v < V_ACT;
   assign edge_px  = border && (h == '0 || h == H_EDGE || v == '0 || v == V_EDGE);
   assign hcount   = h;
   assign vcount   = v;
   assign next_x   = sync || hwrap ? '0 : h + 11'd1;
   assign next_buf = sync ? 1'b0 : hwrap ? ~v[0] : v[0];

`ifdef VGA_TESTPAT_EN
   logic [2:0] bar;
   assign bar = 3'(h / 11'(H_ACTIVE / 8));
   assign src = testpat ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} : pixel;
`else
   logic unused_testpat;
   assign unused_testpat = testpat;
   assign src = pixel;
`endif

   // frame_start fires only when the raster actually moves onto (0,0), so a held sync pulses once
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         h                     <= '0;
         v                     <= '0;
         vga_h                 <= ~HS_POL;
         vga_v                 <= ~VS_POL;
         {vga_b, vga_g, vga_r} <= '0;
         vga_de                <= 1'b0;
         fs_pend               <= 1'b0;
         frame_start           <= 1'b0;
      end else begin
         h                     <= sync || hwrap ? '0 : h + 11'd1;
         v                     <= sync || fwrap ? '0 : hwrap ? v + 11'd1 : v;
         vga_h                 <= sync ? ~HS_POL : h == HS_ON ? HS_POL : h == HS_OFF ? ~HS_POL : vga_h;
         vga_v                 <= sync ? ~VS_POL : h != HS_ON ? vga_v : v == VS_ON ? VS_POL : v == VS_OFF ? ~VS_POL : vga_v;
         vga_de                <= !sync && active;
         {vga_b, vga_g, vga_r} <= !sync && active && !edge_px ? src : '0;
         fs_pend               <= (sync || fwrap) && (h != '0 || v != '0);
         frame_start           <= fs_pend;
      end
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: scoreboard bench for vga_scan_gen in default, reduced-size and active-high-sync configurations.
`timescale 1ns/1ps
module tb_vga_scan_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   logic        d_rst = 1'b1, d_sync = 1'b0, d_border = 1'b0, d_tp = 1'b0;
   logic [11:0] d_pix = '0;
   logic        d_h, d_v, d_de, d_nb, d_fs;
   logic [3:0]  d_r, d_g, d_b;
   logic [10:0] d_hc, d_vc, d_nx;

   logic        s_rst = 1'b1, s_sync = 1'b0, s_border = 1'b0;
   logic [11:0] s_pix = '0;
   logic        s_h, s_v, s_de, s_nb, s_fs;
   logic [3:0]  s_r, s_g, s_b;
   logic [10:0] s_hc, s_vc, s_nx;

   logic        p_rst = 1'b1;
   logic [23:0] p_pix = '0;
   logic        p_h, p_v, p_de, p_nb, p_fs;
   logic [7:0]  p_r, p_g, p_b;
   logic [10:0] p_hc, p_vc, p_nx;

   vga_scan_gen u_d (
      .clk(clk), .reset(d_rst), .sync(d_sync), .border(d_border), .testpat(d_tp), .pixel(d_pix),
      .vga_h(d_h), .vga_v(d_v), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_de(d_de),
      .hcount(d_hc), .vcount(d_vc), .next_x(d_nx), .next_buf(d_nb), .frame_start(d_fs));

   vga_scan_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                  .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_s (
      .clk(clk), .reset(s_rst), .sync(s_sync), .border(s_border), .testpat(1'b0), .pixel(s_pix),
      .vga_h(s_h), .vga_v(s_v), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_de(s_de),
      .hcount(s_hc), .vcount(s_vc), .next_x(s_nx), .next_buf(s_nb), .frame_start(s_fs));

   vga_scan_gen #(.H_ACTIVE(640), .CW(8), .HS_POL(1'b1), .VS_POL(1'b1)) u_p (
      .clk(clk), .reset(p_rst), .sync(1'b0), .border(1'b0), .testpat(1'b0), .pixel(p_pix),
      .vga_h(p_h), .vga_v(p_v), .vga_r(p_r), .vga_g(p_g), .vga_b(p_b), .vga_de(p_de),
      .hcount(p_hc), .vcount(p_vc), .next_x(p_nx), .next_buf(p_nb), .frame_start(p_fs));

   typedef struct packed {logic de; logic [23:0] rgb; logic hs; logic vs; logic fs;} exp_t;
   exp_t sbq[$];

   typedef struct {int h; int v; logic border; logic [11:0] pix; logic [11:0] exp_rgb; logic exp_de;} vec_t;
   vec_t tbl[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_at(input int h, input int v, input string name);
      int g = 0;
      while (!(d_hc == 11'(h) && d_vc == 11'(v)) && g < 3000) begin
         tick();
         g++;
      end
      check(name, 64'({d_hc, d_vc}), 64'({11'(h), 11'(v)}));
   endtask

   task automatic push_d(input logic de, input logic [11:0] rgb);
      exp_t e;
      e = '0;
      e.de = de;
      e.rgb = 24'(rgb);
      sbq.push_back(e);
   endtask

   task automatic pop_d(input string name);
      exp_t e;
      e = sbq.pop_front();
      check(name, 64'({d_de, d_b, d_g, d_r}), 64'({e.de, e.rgb[11:0]}));
   endtask

   initial begin
      int mh, mv, nh, nv, last_fs, cnt_h, cnt_de;
      logic ehs, evs, pend, act, brd, exp_nb;
      logic [10:0] exp_nx;
      exp_t e;

      tbl[0]  = '{0,   0, 1'b1, 12'hFFF, 12'h000, 1'b1};
      tbl[1]  = '{100, 0, 1'b1, 12'hFFF, 12'h000, 1'b1};
      tbl[2]  = '{200, 0, 1'b0, 12'hFFF, 12'hFFF, 1'b1};
      tbl[3]  = '{511, 0, 1'b0, 12'h123, 12'h123, 1'b1};
      tbl[4]  = '{512, 0, 1'b0, 12'hFFF, 12'h000, 1'b0};
      tbl[5]  = '{681, 0, 1'b0, 12'hFFF, 12'h000, 1'b0};
      tbl[6]  = '{0,   1, 1'b1, 12'hFFF, 12'h000, 1'b1};
      tbl[7]  = '{1,   1, 1'b1, 12'hA5C, 12'hA5C, 1'b1};
      tbl[8]  = '{300, 1, 1'b1, 12'h3C3, 12'h3C3, 1'b1};
      tbl[9]  = '{510, 1, 1'b1, 12'hFFF, 12'hFFF, 1'b1};
      tbl[10] = '{511, 1, 1'b1, 12'hFFF, 12'h000, 1'b1};
      tbl[11] = '{512, 1, 1'b1, 12'hFFF, 12'h000, 1'b0};

      repeat (3) tick();
      check("d_reset_vals", 64'({d_hc, d_vc, d_h, d_v, d_de, d_b, d_g, d_r, d_fs}),
            64'({22'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0}));
      check("p_reset_vals", 64'({p_hc, p_vc, p_h, p_v, p_de, p_fs}), 64'({22'd0, 1'b0, 1'b0, 1'b0, 1'b0}));

      d_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wait_at(tbl[i].h, tbl[i].v, $sformatf("d_reach_%0d", i));
         d_border = tbl[i].border;
         d_pix = tbl[i].pix;
         push_d(tbl[i].exp_de, tbl[i].exp_rgb);
         tick();
         pop_d($sformatf("d_vec_%0d", i));
      end

      wait_at(570, 1, "d_reach_hs");
      check("d_hs_before", 64'(d_h), 64'(1'b1));
      tick();
      check("d_hs_assert", 64'(d_h), 64'(1'b0));
      cnt_h = 0;
      cnt_de = 0;
      for (int k = 0; k < 682; k++) begin
         cnt_h += int'(!d_h);
         cnt_de += int'(d_de);
         tick();
      end
      check("d_hs_width", 64'(cnt_h), 64'(82));
      check("d_de_per_line", 64'(cnt_de), 64'(512));

      d_border = 1'b0;
      d_tp = 1'b1;
      d_pix = 12'h0F0;
      wait_at(64, 3, "d_reach_tp1");
`ifdef VGA_TESTPAT_EN
      push_d(1'b1, 12'h00F);
`else
      push_d(1'b1, 12'h0F0);
`endif
      tick();
      pop_d("d_testpat_bar1");
      wait_at(448, 3, "d_reach_tp7");
`ifdef VGA_TESTPAT_EN
      push_d(1'b1, 12'hFFF);
`else
      push_d(1'b1, 12'h0F0);
`endif
      tick();
      pop_d("d_testpat_bar7");
      d_tp = 1'b0;

      wait_at(300, 5, "d_reach_sync");
      d_sync = 1'b1;
      #1;
      check("d_sync_next", 64'({d_nx, d_nb}), 64'({11'd0, 1'b0}));
      tick();
      d_sync = 1'b0;
      check("d_sync_state", 64'({d_hc, d_vc, d_h, d_v, d_de, d_fs}), 64'({22'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
      tick();
      check("d_fs_pulse", 64'(d_fs), 64'(1'b1));
      tick();
      check("d_fs_end", 64'(d_fs), 64'(1'b0));
      d_sync = 1'b1;
      repeat (3) tick();
      check("d_sync_hold", 64'({d_hc, d_vc, d_de}), 64'({22'd0, 1'b0}));
      d_sync = 1'b0;

      wait_at(600, 0, "d_reach_midsync");
      check("d_hs_mid", 64'(d_h), 64'(1'b0));
      #2;
      d_rst = 1'b1;
      #1;
      check("d_async_rst_sync", 64'({d_hc, d_vc, d_h, d_v, d_de, d_b, d_g, d_r, d_fs}),
            64'({22'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0}));
      tick();
      d_rst = 1'b0;
      d_pix = 12'hFFF;
      wait_at(100, 0, "d_reach_midline");
      tick();
      check("d_midline_colour", 64'({d_de, d_b, d_g, d_r}), 64'({1'b1, 12'hFFF}));
      #2;
      d_rst = 1'b1;
      #1;
      check("d_async_rst_line", 64'({d_hc, d_de, d_b, d_g, d_r, d_h}), 64'({11'd0, 1'b0, 12'd0, 1'b1}));

      tick();
      s_rst = 1'b0;
      mh = 0;
      mv = 0;
      ehs = 1'b1;
      evs = 1'b1;
      pend = 1'b0;
      last_fs = -1;
      for (int c = 0; c < 1600; c++) begin
         s_sync = c >= 1000 && ($urandom_range(0, 29) == 0 || (c >= 1300 && c < 1304));
         s_border = c >= 700 ? 1'($urandom_range(0, 1)) : 1'b0;
         s_pix = 12'($urandom);
         #1;
         exp_nx = (s_sync || mh == 31) ? 11'd0 : 11'(mh + 1);
         exp_nb = s_sync ? 1'b0 : (mh == 31) ? ~mv[0] : mv[0];
         check("s_counters", 64'({s_hc, s_vc, s_nx, s_nb}), 64'({11'(mh), 11'(mv), exp_nx, exp_nb}));
         if (s_sync) begin
            nh = 0;
            nv = 0;
            ehs = 1'b1;
            evs = 1'b1;
         end else begin
            nh = (mh == 31) ? 0 : mh + 1;
            nv = (mh != 31) ? mv : (mv == 14) ? 0 : mv + 1;
            if (mh == 20) begin
               ehs = 1'b0;
               if (mv == 10) evs = 1'b0;
               else if (mv == 12) evs = 1'b1;
            end else if (mh == 26) ehs = 1'b1;
         end
         act = !s_sync && mh < 16 && mv < 8;
         brd = s_border && (mh == 0 || mh == 15 || mv == 0 || mv == 7);
         e.de = act;
         e.rgb = (act && !brd) ? 24'(s_pix) : 24'd0;
         e.hs = ehs;
         e.vs = evs;
         e.fs = pend;
         pend = nh == 0 && nv == 0 && !(mh == 0 && mv == 0);
         sbq.push_back(e);
         tick();
         e = sbq.pop_front();
         check("s_outputs", 64'({s_de, s_b, s_g, s_r, s_h, s_v, s_fs}), 64'({e.de, e.rgb[11:0], e.hs, e.vs, e.fs}));
         if (s_fs && c < 1000) begin
            if (last_fs >= 0) check("s_fs_period", 64'(c - last_fs), 64'(480));
            last_fs = c;
         end
         mh = nh;
         mv = nv;
      end
      check("s_fs_seen", 64'(last_fs), 64'(960));

      p_pix = 24'hFFFFFF;
      p_rst = 1'b0;
      cnt_h = 0;
      for (int c = 0; c < 1620; c++) begin
         if (c < 810) cnt_h += int'(p_h);
         if (c % 810 == 809)
            check($sformatf("p_line_end_%0d", c / 810), 64'({p_vc, p_nx, p_nb}),
                  64'({11'(c / 810), 11'd0, ((c / 810) % 2 == 0)}));
         if (c % 810 == 5)
            check($sformatf("p_mid_next_%0d", c / 810), 64'({p_nx, p_nb}), 64'({11'd6, ((c / 810) % 2 == 1)}));
         if (c == 698) check("p_hs_before", 64'(p_h), 64'(1'b0));
         if (c == 699) check("p_hs_assert", 64'({p_h, p_v}), 64'({1'b1, 1'b0}));
         if (c == 640) check("p_last_active", 64'({p_de, p_b, p_g, p_r}), 64'({1'b1, 24'hFFFFFF}));
         if (c == 641) check("p_first_blank", 64'({p_de, p_b, p_g, p_r}), 64'({1'b0, 24'h0}));
         tick();
      end
      check("p_hs_width", 64'(cnt_h), 64'(82));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
